// File: rtl/uart_tx_param.sv
// ============================================================================
// uart_tx_param : UART transmitter fed by a small FIFO, with a runtime baud
//                 divisor. Optional parity is built in with UART_TX_PARITY_EN.
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_WIDTH-1:0]          div,
  input  logic [1:0]                    parity_mode,
  input  logic                          s_valid,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          s_ready,
  output logic                          txd,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int                   c_AW        = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0]        c_DEPTH     = (c_AW+1)'(FIFO_DEPTH);
  localparam logic [DIV_WIDTH-1:0] c_DIV_MIN   = DIV_WIDTH'(2);
  localparam logic [3:0]           c_LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]           c_LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [c_AW-1:0]      wr_ptr_q;
  logic [c_AW-1:0]      rd_ptr_q;
  logic [c_AW:0]        count_q;
  logic                 w_push;
  logic                 w_pop;

  // Frame engine
  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 txd_q, txd_d;
  logic                 busy_q;
  logic                 done_q, done_d;
  logic [DIV_WIDTH-1:0] w_div_eff;
  logic                 w_bit_end;

`ifdef UART_TX_PARITY_EN
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
`else
  logic                 w_unused_parity;
  assign w_unused_parity = ^parity_mode;
`endif

  assign s_ready    = !rst && (count_q != c_DEPTH);
  assign w_push     = s_valid && s_ready;
  assign fifo_level = count_q;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign done       = done_q;

  assign w_div_eff  = (div < c_DIV_MIN) ? c_DIV_MIN : div;
  assign w_bit_end  = (cnt_q == div_q - 1'b1);

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      div_q     <= c_DIV_MIN;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      div_q     <= div_d;
      txd_q     <= txd_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  // txd is registered, so it is driven from the level of the state being entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    div_d     = div_q;
    txd_d     = txd_q;
    done_d    = 1'b0;
    w_pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    if (state_q != IDLE) begin
      cnt_d = w_bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (count_q != '0) begin
          w_pop     = 1'b1;
          sh_d      = mem_q[rd_ptr_q];
          div_d     = w_div_eff;
          cnt_d     = '0;
          state_d   = START;
          txd_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          par_bit_d = (^mem_q[rd_ptr_q]) ^ parity_mode[1];
`endif
        end
      end
      START: begin
        if (w_bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          txd_d   = sh_q[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (bit_q == c_LAST_DATA) begin
            state_d = STOP;
            bit_d   = '0;
            txd_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = PARITY;
              txd_d   = par_bit_q;
            end
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = sh_q >> 1;
            txd_d = sh_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          state_d = STOP;
          bit_d   = '0;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        txd_d = 1'b1;
        if (w_bit_end) begin
          if (bit_q == c_LAST_STOP) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_param.sv
// ============================================================================
// tb_uart_tx_param : randomized self-checking bench for uart_tx_param; line
//                    waveforms are predicted from frame composition rules.
// Revision         : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  // 8-bit, 1 stop, depth 4
  logic [15:0] div;
  logic [1:0]  mode;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready, txd, busy, done;
  logic [2:0]  fifo_level;
  // 9-bit, 2 stop, depth 2
  logic [15:0] div2;
  logic [1:0]  mode2;
  logic        s_valid2;
  logic [8:0]  s_data2;
  logic        s_ready2, txd2, busy2, done2;
  logic [1:0]  fifo_level2;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .DIV_WIDTH(16), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .div(div), .parity_mode(mode), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .txd(txd), .busy(busy), .done(done),
    .fifo_level(fifo_level)
  );

  uart_tx_param #(.DATA_BITS(9), .STOP_BITS(2), .DIV_WIDTH(16), .FIFO_DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .div(div2), .parity_mode(mode2), .s_valid(s_valid2),
    .s_data(s_data2), .s_ready(s_ready2), .txd(txd2), .busy(busy2), .done(done2),
    .fifo_level(fifo_level2)
  );

  int         total = 0;
  int         bad   = 0;
  bit         rec   = 1'b0;
  int         sel   = 0;
  logic [2:0] cap[$];   // {txd, busy, done} per captured cycle
  logic [2:0] expq[$];

  function automatic bit parity_used(input int m);
    return PAR_ON && (m == 1 || m == 2);
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rec) cap.push_back((sel == 1) ? {txd2, busy2, done2} : {txd, busy, done});
  endtask

  task automatic clear_q();
    cap.delete();
    expq.delete();
  endtask

  // One frame as the line should show it, followed by its done/idle cycle.
  task automatic model_frame(input logic [8:0] d, input int nb, input int dv,
                             input int m, input int sb);
    int   e;
    int   ones;
    logic lv[$];
    e    = (dv < 2) ? 2 : dv;
    ones = 0;
    lv.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      lv.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (parity_used(m)) lv.push_back(((ones % 2) == 1) ^ (m == 2));
    for (int i = 0; i < sb; i++) lv.push_back(1'b1);
    foreach (lv[i]) repeat (e) expq.push_back({lv[i], 1'b1, 1'b0});
    expq.push_back(3'b101);
  endtask

  task automatic model_idle(input int n);
    repeat (n) expq.push_back(3'b100);
  endtask

  function automatic int first_diff();
    int n;
    n = (cap.size() < expq.size()) ? cap.size() : expq.size();
    for (int i = 0; i < n; i++) if (cap[i] !== expq[i]) return i;
    if (cap.size() != expq.size()) return n;
    return -1;
  endfunction

  function automatic logic [2:0] cap_at(input int i);
    return (i < cap.size()) ? cap[i] : 3'bxxx;
  endfunction

  function automatic logic [2:0] exp_at(input int i);
    return (i < expq.size()) ? expq[i] : 3'bxxx;
  endfunction

  // Write one word into the first instance and capture until the model is covered.
  task automatic send1(input logic [7:0] d, input int dv, input int m);
    tick();
    s_valid = 1'b1; s_data = d; div = 16'(dv); mode = 2'(m);
    tick();
    s_valid = 1'b0;
    rec = 1'b1;
    while (cap.size() < expq.size()) tick();
    rec = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (txd !== 1'b1)        begin bad++; $display("FAIL rst_txd got %b want 1", txd); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL rst_done got %b want 0", done); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    total++; if (s_ready !== 1'b0)    begin bad++; $display("FAIL rst_ready got %b want 0", s_ready); end
    rst = 1'b0;
    tick();
    total++; if (s_ready !== 1'b1)    begin bad++; $display("FAIL rst_ready_after got %b want 1", s_ready); end
    total++; if (s_ready2 !== 1'b1)   begin bad++; $display("FAIL rst_ready2_after got %b want 1", s_ready2); end
  endtask

  task automatic test_basic();
    int d;
    int ndone;
    clear_q();
    model_frame(9'h0A5, 8, 4, 0, 1);
    model_idle(3);
    send1(8'hA5, 4, 0);
    d = first_diff();
    total++;
    if (d >= 0) begin bad++; $display("FAIL basic_wave cycle %0d got %b want %b", d, cap_at(d), exp_at(d)); end
    // capture starts two cycles after the write: done belongs at offset 40 only
    ndone = 0;
    foreach (cap[i]) if (cap[i][0] === 1'b1) ndone++;
    total++;
    if (cap_at(40) !== 3'b101 || ndone != 1) begin
      bad++; $display("FAIL basic_done got %b (pulses %0d) want 101 (pulses 1)", cap_at(40), ndone);
    end
  endtask

  task automatic test_parity();
    logic [7:0] pd [3];
    int         pm [3];
    logic       pexp [3];
    int         d;
    pd = '{8'hA5, 8'hA5, 8'h01};
    pm = '{1, 2, 1};
    // Without parity the slot after bit 7 is already the stop bit.
    pexp = PAR_ON ? '{1'b0, 1'b1, 1'b1} : '{1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      clear_q();
      model_frame({1'b0, pd[k]}, 8, 4, pm[k], 1);
      model_idle(2);
      send1(pd[k], 4, pm[k]);
      d = first_diff();
      total++;
      if (d >= 0) begin bad++; $display("FAIL parity_wave[%0d] cycle %0d got %b want %b", k, d, cap_at(d), exp_at(d)); end
      total++;
      if (cap_at(36)[2] !== pexp[k]) begin
        bad++; $display("FAIL parity_bit[%0d] got %b want %b", k, cap_at(36)[2], pexp[k]);
      end
    end
  endtask

  task automatic test_fifo_back_to_back();
    int idx;
    int maxl;
    bit saw_full;
    int d;
    clear_q();
    for (int k = 0; k < 6; k++) model_frame(9'(9'h010 + k), 8, 2, 0, 1);
    model_idle(3);
    idx = 1; maxl = 0; saw_full = 1'b0;
    tick();
    s_valid = 1'b1; s_data = 8'h10; div = 16'd2; mode = 2'd0;
    tick();
    rec = 1'b1;
    while (cap.size() < expq.size()) begin
      if (idx < 6) begin
        s_valid = 1'b1;
        s_data  = 8'(8'h10 + idx);
        if (s_ready) idx++; else saw_full = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      tick();
      if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
    end
    s_valid = 1'b0;
    rec = 1'b0;
    d = first_diff();
    total++;
    if (d >= 0) begin bad++; $display("FAIL fifo_wave cycle %0d got %b want %b", d, cap_at(d), exp_at(d)); end
    total++;
    if (!saw_full || maxl != 4) begin bad++; $display("FAIL fifo_full got saw_full=%0d max_level=%0d want 1/4", saw_full, maxl); end
    total++;
    if (idx != 6) begin bad++; $display("FAIL fifo_accept got %0d words want 6", idx); end
  endtask

  task automatic test_div_min();
    logic [7:0] dat;
    int         m;
    int         d;
    for (int dv = 0; dv < 2; dv++) begin
      dat = 8'($urandom);
      m   = int'($urandom_range(0, 3));
      clear_q();
      model_frame({1'b0, dat}, 8, dv, m, 1);
      model_idle(2);
      send1(dat, dv, m);
      d = first_diff();
      total++;
      if (d >= 0) begin bad++; $display("FAIL div_min[%0d] cycle %0d got %b want %b", dv, d, cap_at(d), exp_at(d)); end
    end
  endtask

  task automatic test_div_change();
    logic [7:0] d1, d2;
    int         m;
    int         d;
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    m  = int'($urandom_range(0, 3));
    clear_q();
    model_frame({1'b0, d1}, 8, 4, m, 1);
    model_frame({1'b0, d2}, 8, 8, m, 1);
    model_idle(3);
    tick();
    s_valid = 1'b1; s_data = d1; div = 16'd4; mode = 2'(m);
    tick();
    s_valid = 1'b0;
    rec = 1'b1;
    while (cap.size() < expq.size()) begin
      tick();
      if (cap.size() == 10) begin
        div = 16'd8; s_valid = 1'b1; s_data = d2;
      end else begin
        s_valid = 1'b0;
      end
    end
    rec = 1'b0;
    d = first_diff();
    total++;
    if (d >= 0) begin bad++; $display("FAIL div_change cycle %0d got %b want %b", d, cap_at(d), exp_at(d)); end
  endtask

  task automatic test_stop2();
    logic [8:0] dat;
    int         dv;
    int         m;
    int         d;
    sel = 1;
    for (int k = 0; k < 3; k++) begin
      dat = 9'($urandom);
      dv  = (k == 0) ? 3 : int'($urandom_range(0, 5));
      m   = int'($urandom_range(0, 3));
      clear_q();
      model_frame(dat, 9, dv, m, 2);
      model_idle(2);
      tick();
      s_valid2 = 1'b1; s_data2 = dat; div2 = 16'(dv); mode2 = 2'(m);
      tick();
      s_valid2 = 1'b0;
      rec = 1'b1;
      while (cap.size() < expq.size()) tick();
      rec = 1'b0;
      d = first_diff();
      total++;
      if (d >= 0) begin bad++; $display("FAIL stop2_wave[%0d] div=%0d cycle %0d got %b want %b", k, dv, d, cap_at(d), exp_at(d)); end
    end
    sel = 0;
  endtask

  task automatic test_random();
    logic [7:0] dat;
    int         dv;
    int         m;
    int         d;
    for (int k = 0; k < 6; k++) begin
      dat = 8'($urandom);
      dv  = int'($urandom_range(0, 6));
      m   = int'($urandom_range(0, 3));
      clear_q();
      model_frame({1'b0, dat}, 8, dv, m, 1);
      model_idle(2);
      send1(dat, dv, m);
      d = first_diff();
      total++;
      if (d >= 0) begin bad++; $display("FAIL random_wave[%0d] data=%h div=%0d mode=%0d cycle %0d got %b want %b", k, dat, dv, m, d, cap_at(d), exp_at(d)); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d1, d2;
    bit         quiet;
    int         d;
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    clear_q();
    model_frame({1'b0, d1}, 8, 4, 0, 1);
    while (expq.size() > 19) void'(expq.pop_back());
    tick();
    s_valid = 1'b1; s_data = d1; div = 16'd4; mode = 2'd0;
    tick();
    s_data = d2;
    rec = 1'b1;
    tick();
    s_valid = 1'b0;
    total++;
    if (fifo_level !== 3'd1) begin bad++; $display("FAIL push_pop_level got %0d want 1", fifo_level); end
    while (cap.size() < 19) tick();
    rec = 1'b0;
    rst = 1'b1;   // line is now in data bit 3
    d = first_diff();
    total++;
    if (d >= 0) begin bad++; $display("FAIL pre_reset_wave cycle %0d got %b want %b", d, cap_at(d), exp_at(d)); end
    tick();
    total++;
    if ({txd, busy, done} !== 3'b100 || fifo_level !== 3'd0) begin
      bad++; $display("FAIL midframe_rst got txd/busy/done=%b level=%0d want 100 level=0", {txd, busy, done}, fifo_level);
    end
    rst = 1'b0;
    quiet = 1'b1;
    repeat (60) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || fifo_level !== 3'd0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin bad++; $display("FAIL flush_quiet got activity after reset want idle line"); end
    clear_q();
    model_frame({1'b0, d2}, 8, 4, 2, 1);
    model_idle(2);
    send1(d2, 4, 2);
    d = first_diff();
    total++;
    if (d >= 0) begin bad++; $display("FAIL post_reset_wave cycle %0d got %b want %b", d, cap_at(d), exp_at(d)); end
  endtask

  initial begin
    rst = 1'b1;
    div = 16'd4;  mode = 2'd0;  s_valid = 1'b0;  s_data = 8'h00;
    div2 = 16'd3; mode2 = 2'd0; s_valid2 = 1'b0; s_data2 = 9'h000;
    test_reset();
    test_basic();
    test_parity();
    test_fifo_back_to_back();
    test_div_min();
    test_div_change();
    test_stop2();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with an input FIFO, runtime baud divisor, configurable data width, stop-bit count and optional parity. It sits between the capture/readout logic and the host serial link. Bytes are pushed through a valid/ready stream and serialised back-to-back with no software pacing.

## Interface
- DATA_BITS, 8, data bits per frame, legal 5..9
- STOP_BITS, 1, stop bits per frame, legal 1 or 2
- DIV_WIDTH, 16, width of the runtime clocks-per-bit divisor
- FIFO_DEPTH, 4, input FIFO entries, power of two, ≥2

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- div  in  DIV_WIDTH  clocks per bit; sampled at frame load; values 0 and 1 are treated as 2
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none; sampled at frame load
- s_valid  in  1  input word valid
- s_data  in  DATA_BITS  input word, transmitted LSB first
- s_ready  out  1  FIFO not full; write occurs when s_valid && s_ready
- txd  out  1  serial line, registered, idle high
- busy  out  1  high while a frame is on the line (START through final STOP cycle)
- done  out  1  one-cycle pulse after each frame's last stop cycle
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently held

## Operation
- Reset values: txd=1, busy=0, done=0, fifo_level=0, s_ready=0 while rst high, 1 in the first cycle after.
- Reset mid-frame: frame abandoned, FIFO flushed, state IDLE, no done pulse.
- FIFO: first-word not visible in the write cycle; a write with FIFO full is impossible (s_ready=0). Write and pop in the same cycle both take effect, level unchanged.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: txd=1. If FIFO non-empty: pop, latch data, effective div, parity_mode; next START.
- START: txd=0 for div cycles; next DATA.
- DATA: bit index 0..DATA_BITS-1, each held div cycles; after last bit, next PARITY if parity active, else STOP.
- PARITY: txd = XOR of data bits (even) or its inverse (odd), div cycles; next STOP.
- STOP: txd=1 for STOP_BITS*div cycles; next IDLE, done=1 in that IDLE cycle.
- Bit counter wide enough for 9; cycle counter DIV_WIDTH bits, counts 0..div-1, no wrap beyond.
- div and parity_mode changes mid-frame have no effect on the current frame.

## Timing
- Write into empty FIFO at cycle N → pop at end of N+1 → txd low from cycle N+2; busy high from N+2.
- Frame length on line: (1 + DATA_BITS + P + STOP_BITS) * div cycles, P ∈ {0,1}.
- Back-to-back: exactly one IDLE cycle (txd=1, busy=0, done=1) between a frame's final stop cycle and the next start bit; this IDLE cycle performs the pop.
- done coincides with the IDLE cycle following STOP; never asserted twice per frame.

## Configuration
- UART_TX_PARITY_EN defined: parity_mode honoured, PARITY state present.
- Not defined: parity_mode port present but ignored, P=0 always, PARITY state and parity logic removed.

## Test plan
- DATA_BITS=8, div=4, mode 00, write 0xA5 at cycle N → txd low N+2..N+5, then 1,0,1,0,0,1,0,1 each 4 cycles, stop 4 cycles, done at N+42 only.
- UART_TX_PARITY_EN, div=4, 0xA5 even → parity bit 0; odd → 1; 0x01 even → 1; frame 44 cycles.
- FIFO_DEPTH=4, div=2, s_valid held for 6 words 0x10..0x15 → s_ready drops once 4 held, all 6 frames in order, exactly one idle cycle between frames, 6 done pulses.
- rst asserted during data bit 3 → next cycle txd=1, busy=0, fifo_level=0, no done; subsequent write transmits normally.
- div=0 and div=1 → each bit lasts 2 cycles; STOP_BITS=2, div=3 → stop held 6 cycles.
- Change div from 4 to 8 mid-frame → current frame stays at 4, next frame at 8.
